// File: rtl/ddr3_lane_read_dly_trainer.sv
// Per-lane DDR3 read-delay trainer: sweeps the delay tap, finds the passing window, parks at its centre.
// Define EYE_MONITOR_TRACK_EN to enable eye-monitor tracking after training completes.
module ddr3_lane_read_dly_trainer #(
    parameter int         TAP_MAX        = 128,
    parameter int         SETTLE_CYCLES  = 8,
    parameter int         PASS_CNT       = 16,
    parameter int         MIN_WIN        = 8,
    parameter logic [7:0] PATTERN        = 8'h55,
    parameter int         TRACK_INTERVAL = 256
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       TRAIN_START,
    input  logic [7:0] RX_DATA,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       TRAIN_BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [7:0] WIN_START,
    output logic [7:0] WIN_END,
    output logic [7:0] TAP_CUR
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_STEP, S_CENTER, S_DONE, S_ERR
`ifdef EYE_MONITOR_TRACK_EN
        , S_TRACK
`endif
    } state_t;

    localparam logic [7:0]  TAP_LAST    = 8'(TAP_MAX - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PASS_LAST   = 16'(PASS_CNT - 1);
    localparam logic [8:0]  MIN_WIN_W   = 9'(MIN_WIN);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tap_q, tap_d, ws_q, ws_d, we_q, we_d;
    logic        in_win_q, in_win_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        tog_q, tog_d, cfin_q, cfin_d, clr_q, clr_d;

    logic [8:0]  win_sum, win_width;
    logic [7:0]  target;
    logic        win_ok, at_end, rx_match, center_move, track_inc, track_dec;

    // Centre target uses a 9-bit sum so taps near 255 cannot overflow.
    assign win_sum     = {1'b0, ws_q} + {1'b0, we_q};
    assign target      = 8'(win_sum >> 1);
    assign win_width   = {1'b0, we_q} - {1'b0, ws_q} + 9'd1;
    assign win_ok      = (win_width >= MIN_WIN_W);
    assign at_end      = (tap_q == TAP_LAST) || DELAY_LINE_OUT_OF_RANGE;
    assign rx_match    = (RX_DATA == PATTERN);
    assign center_move = (state_q == S_CENTER) && win_ok && (tap_q != target) && !tog_q;

`ifdef EYE_MONITOR_TRACK_EN
    logic track_tick;
    assign track_tick = (state_q == S_TRACK) && (cnt_q == 16'(TRACK_INTERVAL - 1));
    assign track_inc  = track_tick && EYE_MONITOR_EARLY && !EYE_MONITOR_LATE && (tap_q != TAP_LAST);
    assign track_dec  = track_tick && EYE_MONITOR_LATE && !EYE_MONITOR_EARLY && (tap_q != 8'd0);
`else
    localparam int unused_track_interval = TRACK_INTERVAL;
    logic unused_eye_flags;
    assign unused_eye_flags = EYE_MONITOR_EARLY ^ EYE_MONITOR_LATE;
    assign track_inc = 1'b0;
    assign track_dec = 1'b0;
`endif

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tap_q    <= '0;
            ws_q     <= '0;
            we_q     <= '0;
            in_win_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tog_q    <= 1'b0;
            cfin_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tap_q    <= tap_d;
            ws_q     <= ws_d;
            we_q     <= we_d;
            in_win_q <= in_win_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tog_q    <= tog_d;
            cfin_q   <= cfin_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tap_d    = tap_q;
        ws_d     = ws_q;
        we_d     = we_q;
        in_win_d = in_win_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        tog_d    = tog_q;
        cfin_d   = cfin_q;
        clr_d    = 1'b0;
        case (state_q)
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (cfin_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SAMPLE: begin
                if (rx_match && cnt_q != PASS_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (rx_match) begin
                    if (!in_win_q) ws_d = tap_q;
                    in_win_d = 1'b1;
                    we_d     = tap_q;
                    tog_d    = 1'b0;
                    state_d  = at_end ? S_CENTER : S_STEP;
                end else if (in_win_q) begin
                    tog_d   = 1'b0;
                    state_d = S_CENTER;
                end else if (at_end) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                tap_d   = tap_q + 8'd1;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            // Back off toward the centre, one decrement every other cycle.
            S_CENTER: begin
                if (!win_ok) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (tap_q == target) begin
                    cfin_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (!tog_q) begin
                    tap_d = tap_q - 8'd1;
                    tog_d = 1'b1;
                end else begin
                    tog_d = 1'b0;
                end
            end
`ifdef EYE_MONITOR_TRACK_EN
            S_DONE: begin
                state_d = S_TRACK;
                cnt_d   = '0;
            end
            S_TRACK: begin
                if (track_tick) begin
                    cnt_d = '0;
                    clr_d = 1'b1;
                    if (track_inc) tap_d = tap_q + 8'd1;
                    if (track_dec) tap_d = tap_q - 8'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            default: ;
        endcase
        // Idle, done, error and tracking are exactly the states where busy is low.
        if (TRAIN_START && !busy_q) begin
            state_d  = S_LOAD;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            err_d    = 1'b0;
            ws_d     = '0;
            we_d     = '0;
            tap_d    = '0;
            in_win_d = 1'b0;
            cfin_d   = 1'b0;
            tog_d    = 1'b0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        DELAY_LINE_LOAD      = (state_q == S_LOAD);
        DELAY_LINE_MOVE      = (state_q == S_STEP) || center_move || track_inc || track_dec;
        DELAY_LINE_DIRECTION = (state_q == S_STEP) || track_inc;
    end

    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign TRAIN_BUSY = busy_q;
    assign TRAIN_DONE = done_q;
    assign TRAIN_ERR  = err_q;
    assign WIN_START  = ws_q;
    assign WIN_END    = we_q;
    assign TAP_CUR    = tap_q;

endmodule

// File: tb/tb_ddr3_lane_read_dly_trainer.sv
// Bench for ddr3_lane_read_dly_trainer: randomized lane model driven by the delay-line pulses,
// results compared against a window/centre reference computed arithmetically per scenario.
module tb_ddr3_lane_read_dly_trainer;

    localparam int         TAP_MAX  = 128;
    localparam int         SETTLE   = 8;
    localparam int         PASS     = 16;
    localparam int         MIN_WIN  = 8;
    localparam int         TRACK_IV = 256;
    localparam logic [7:0] PAT      = 8'h55;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N = 1'b0;
    logic       TRAIN_START = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       OOR = 1'b0;
    logic       EARLY = 1'b0;
    logic       LATE = 1'b0;
    logic       LOAD, MOVE, DIR, CLR, BUSY, DONE, ERR;
    logic [7:0] WS, WE, TAP;

    ddr3_lane_read_dly_trainer #(
        .TAP_MAX(TAP_MAX), .SETTLE_CYCLES(SETTLE), .PASS_CNT(PASS), .MIN_WIN(MIN_WIN),
        .PATTERN(PAT), .TRACK_INTERVAL(TRACK_IV)
    ) dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .TRAIN_START(TRAIN_START), .RX_DATA(RX_DATA),
        .DELAY_LINE_OUT_OF_RANGE(OOR), .EYE_MONITOR_EARLY(EARLY), .EYE_MONITOR_LATE(LATE),
        .DELAY_LINE_LOAD(LOAD), .DELAY_LINE_MOVE(MOVE), .DELAY_LINE_DIRECTION(DIR),
        .EYE_MONITOR_CLEAR_FLAGS(CLR), .TRAIN_BUSY(BUSY), .TRAIN_DONE(DONE), .TRAIN_ERR(ERR),
        .WIN_START(WS), .WIN_END(WE), .TAP_CUR(TAP)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int checks = 0;
    int errors = 0;
    int lo = 1, hi = 0, oor_tap = 1000;
    int dtap = 0;
    int cyc = 0, n_load = 0, n_inc = 0, n_dec = 0, n_clr = 0, n_clr_ok = 0;
    int viol = 0, last_dec = -1000, run = 0;
    bit loaded = 1'b0, prev_move = 1'b0;
    int move_cyc [256];

    // Delay-line and lane model: follows LOAD/MOVE pulses and produces data for the current tap.
    always @(negedge FAB_CLK) begin
        cyc++;
        if (!ARST_N) loaded = 1'b0;
        if (LOAD) begin
            n_load++;
            loaded = 1'b1;
            if (MOVE) viol++;
        end
        if (MOVE) begin
            if (prev_move || !loaded) viol++;
            if (DIR) begin
                if (dtap >= 0 && dtap < 256) move_cyc[dtap] = cyc;
                n_inc++;
                dtap++;
            end else begin
                if (cyc - last_dec != 2 && cyc - last_dec < 50) viol++;
                last_dec = cyc;
                n_dec++;
                dtap--;
            end
        end
        if (LOAD) dtap = 0;
        if (CLR) begin
            n_clr++;
            if (prev_move) n_clr_ok++;
        end
        prev_move = MOVE;
        OOR = (dtap >= oor_tap);
        if (dtap >= lo && dtap <= hi) begin
            RX_DATA = PAT;
        end else if (run < 5 && $urandom_range(0, 1) == 1) begin
            RX_DATA = PAT;
            run++;
        end else begin
            RX_DATA = 8'($urandom_range(0, 255));
            if (RX_DATA == PAT) RX_DATA = ~PAT;
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge FAB_CLK);
            if (DONE || ERR) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference: the sweep stops at the first tap past the window or at the end stop.
    task automatic model(input int l, input int h, input int o,
                         output int ok, output int ws, output int we, output int tap, output int dec);
        int end_tap, close;
        end_tap = (o < TAP_MAX - 1) ? o : TAP_MAX - 1;
        if (l > h || l > end_tap) begin
            ok = 0; ws = 0; we = 0; tap = end_tap; dec = 0;
        end else begin
            ws    = l;
            we    = (h < end_tap) ? h : end_tap;
            close = (h < end_tap) ? h + 1 : we;
            if (we - ws + 1 < MIN_WIN) begin
                ok = 0; tap = close; dec = 0;
            end else begin
                ok = 1; tap = (ws + we) / 2; dec = close - tap;
            end
        end
    endtask

    task automatic run_scn(input string nm, input int l, input int h, input int o, input bit mid);
        int e_ok, e_ws, e_we, e_tap, e_dec, b_dec, b_load, b_viol;
        bit ok;
        lo = l; hi = h; oor_tap = o;
        b_dec = n_dec; b_load = n_load; b_viol = viol;
        pulse_start();
        check({nm, "_busy_rise"}, BUSY, 1);
        check({nm, "_done_clr"}, {DONE, ERR}, 0);
        if (mid) begin
            repeat (200) @(negedge FAB_CLK);
            TRAIN_START = 1'b1;
            @(negedge FAB_CLK);
            TRAIN_START = 1'b0;
        end
        wait_end(ok);
        check({nm, "_finished"}, ok, 1);
        model(l, h, o, e_ok, e_ws, e_we, e_tap, e_dec);
        check({nm, "_done"}, DONE, e_ok);
        check({nm, "_err"}, ERR, 1 - e_ok);
        check({nm, "_win_start"}, WS, e_ws);
        check({nm, "_win_end"}, WE, e_we);
        check({nm, "_tap_cur"}, TAP, e_tap);
        check({nm, "_line_tap"}, dtap, e_tap);
        check({nm, "_dec_moves"}, n_dec - b_dec, e_dec);
        check({nm, "_busy_fall"}, BUSY, 0);
        check({nm, "_loads"}, n_load - b_load, 1);
        check({nm, "_protocol"}, viol - b_viol, 0);
    endtask

    initial begin
        bit ok;
        int b_clr, b_ok, b_inc, l, w, o;
        repeat (3) @(negedge FAB_CLK);
        check("reset_outputs", {LOAD, MOVE, DIR, CLR, BUSY, DONE, ERR, WS, WE, TAP}, 0);
        ARST_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);

        run_scn("win20_60", 20, 60, 1000, 1'b1);
        check("pass_tap_cost", move_cyc[30] - move_cyc[29], 1 + SETTLE + PASS);

        b_clr = n_clr; b_ok = n_clr_ok; b_inc = n_inc;
        EARLY = 1'b1;
`ifdef EYE_MONITOR_TRACK_EN
        for (int i = 0; i < 4 * TRACK_IV && n_clr - b_clr < 3; i++) @(negedge FAB_CLK);
        EARLY = 1'b0;
        check("track_tap", TAP, 43);
        check("track_line_tap", dtap, 43);
        check("track_inc_moves", n_inc - b_inc, 3);
        check("track_clear_after_move", n_clr_ok - b_ok, 3);
        check("track_clears", n_clr - b_clr, 3);
`else
        repeat (3 * TRACK_IV + 20) @(negedge FAB_CLK);
        EARLY = 1'b0;
        check("frozen_tap", TAP, 40);
        check("frozen_moves", n_inc - b_inc, 0);
        check("frozen_clears", n_clr - b_clr, 0);
`endif

        run_scn("narrow10_14", 10, 14, 1000, 1'b0);
        run_scn("endstop100", 100, 200, 127, 1'b0);
        run_scn("no_window", 1, 0, 1000, 1'b0);

        lo = 20; hi = 60; oor_tap = 1000;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge FAB_CLK);
            if (TAP == 8'd30) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_tap30", ok, 1);
        ARST_N = 1'b0;
        #1;
        check("abort_outputs", {LOAD, MOVE, DIR, CLR, BUSY, DONE, ERR, WS, WE, TAP}, 0);
        repeat (3) @(negedge FAB_CLK);
        ARST_N = 1'b1;
        run_scn("after_abort", 20, 60, 1000, 1'b0);

        for (int t = 0; t < 3; t++) begin
            l = $urandom_range(0, 110);
            w = $urandom_range(1, 30);
            o = ($urandom_range(0, 1) == 1) ? 1000 : $urandom_range(l, 127);
            run_scn($sformatf("rand%0d", t), l, l + w - 1, o, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
